// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans the calculator's 5x5 key matrix one column at a time and debounces the
// whole matrix. The result is a clean, level-valued calc_pkg::buttons_t vector
// for the downstream button sanitizer. This block does no edge detection and
// no priority resolution.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   row_ni[4:0]  matrix rows, active-low (external pull-ups), async to clk_i
//   col_no[4:0]  column drive, active-low, exactly one bit low at all times
//   buttons_o    debounced pressed state, 1 = pressed
//   scan_done_o  one-cycle pulse while the scan is evaluated (S_EVAL)
//
// Key index k = col*5 + row. k = 0..22 map in order to on, off, mem_rc,
// mem_sub, mem_add, op_percent, op_sqrt, op_div, op_mul, op_sub, op_add,
// op_eq, dot, num_1..num_9, num_0. k = 23 and 24 are unpopulated.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package calc_pkg;

  typedef struct packed {
    logic on;
    logic off;
    logic mem_rc;
    logic mem_sub;
    logic mem_add;
    logic op_percent;
    logic op_sqrt;
    logic op_div;
    logic op_mul;
    logic op_sub;
    logic op_add;
    logic op_eq;
    logic dot;
    logic num_1;
    logic num_2;
    logic num_3;
    logic num_4;
    logic num_5;
    logic num_6;
    logic num_7;
    logic num_8;
    logic num_9;
    logic num_0;
  } buttons_t;

endpackage

module keypad_scanner #(
  parameter int unsigned SETTLE_CYCLES  = 16, // 3..255
  parameter int unsigned DEBOUNCE_SCANS = 4   // 1..15
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [4:0]         row_ni,
  output logic [4:0]         col_no,
  output calc_pkg::buttons_t buttons_o,
  output logic               scan_done_o
);

  typedef enum logic [1:0] {
    S_SETTLE,
    S_SAMPLE,
    S_EVAL
  } state_e;

  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] StableMax  = 4'(DEBOUNCE_SCANS);

  // Row synchronizer
  logic [4:0] row_meta_q;
  logic [4:0] row_sync_q;

  // Scan state
  state_e             state_q;
  logic [2:0]         col_idx_q;
  logic [7:0]         settle_q;
  logic [4:0]         col_q;
  logic [22:0]        snap_q;
  logic [22:0]        prev_q;
  logic [3:0]         stable_q;
  calc_pkg::buttons_t buttons_q;
  logic               scan_done_q;

  // Next-state helpers
  logic [22:0]        snap_d;
  logic [3:0]         stable_d;
  calc_pkg::buttons_t snap_btn;
  logic [4:0]         pressed;

  // Two-flop synchronizer; idle rows are pulled high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= row_ni;
      row_sync_q <= row_meta_q;
    end
  end

  assign pressed = ~row_sync_q;

  // Merge the current column's rows into the snapshot. Column 4 only has
  // three populated rows, so rows 3 and 4 of that column are dropped.
  always_comb begin
    snap_d = snap_q;
    unique case (col_idx_q)
      3'd0:    snap_d[4:0]   = pressed;
      3'd1:    snap_d[9:5]   = pressed;
      3'd2:    snap_d[14:10] = pressed;
      3'd3:    snap_d[19:15] = pressed;
      3'd4:    snap_d[22:20] = pressed[2:0];
      default: snap_d        = snap_q;
    endcase
  end

  // Whole-matrix stability count, saturating at DEBOUNCE_SCANS.
  always_comb begin
    stable_d = 4'd1;
    if (snap_q == prev_q) begin
      if (stable_q >= StableMax) begin
        stable_d = StableMax;
      end else begin
        stable_d = stable_q + 4'd1;
      end
    end
  end

  // Map key index to named fields explicitly so the result does not depend
  // on the packed field order of buttons_t.
  always_comb begin
    snap_btn            = '0;
    snap_btn.on         = snap_q[0];
    snap_btn.off        = snap_q[1];
    snap_btn.mem_rc     = snap_q[2];
    snap_btn.mem_sub    = snap_q[3];
    snap_btn.mem_add    = snap_q[4];
    snap_btn.op_percent = snap_q[5];
    snap_btn.op_sqrt    = snap_q[6];
    snap_btn.op_div     = snap_q[7];
    snap_btn.op_mul     = snap_q[8];
    snap_btn.op_sub     = snap_q[9];
    snap_btn.op_add     = snap_q[10];
    snap_btn.op_eq      = snap_q[11];
    snap_btn.dot        = snap_q[12];
    snap_btn.num_1      = snap_q[13];
    snap_btn.num_2      = snap_q[14];
    snap_btn.num_3      = snap_q[15];
    snap_btn.num_4      = snap_q[16];
    snap_btn.num_5      = snap_q[17];
    snap_btn.num_6      = snap_q[18];
    snap_btn.num_7      = snap_q[19];
    snap_btn.num_8      = snap_q[20];
    snap_btn.num_9      = snap_q[21];
    snap_btn.num_0      = snap_q[22];
  end

  // Scan sequencer with registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_SETTLE;
      col_idx_q   <= '0;
      settle_q    <= '0;
      col_q       <= 5'b11110;
      snap_q      <= '0;
      prev_q      <= '0;
      stable_q    <= '0;
      buttons_q   <= '0;
      scan_done_q <= 1'b0;
    end else begin
      scan_done_q <= 1'b0;
      unique case (state_q)
        S_SETTLE: begin
          if (settle_q == SettleLast) begin
            state_q <= S_SAMPLE;
          end else begin
            settle_q <= settle_q + 8'd1;
          end
        end

        S_SAMPLE: begin
          snap_q   <= snap_d;
          settle_q <= '0;
          if (col_idx_q == 3'd4) begin
            state_q     <= S_EVAL;
            scan_done_q <= 1'b1;
          end else begin
            state_q   <= S_SETTLE;
            col_idx_q <= col_idx_q + 3'd1;
            col_q     <= ~(5'b00001 << (col_idx_q + 3'd1));
          end
        end

        S_EVAL: begin
          stable_q <= stable_d;
          prev_q   <= snap_q;
          if (stable_d == StableMax) begin
            buttons_q <= snap_btn;
          end
          state_q   <= S_SETTLE;
          col_idx_q <= '0;
          settle_q  <= '0;
          col_q     <= 5'b11110;
        end

        default: begin
          state_q   <= S_SETTLE;
          col_idx_q <= '0;
          settle_q  <= '0;
          col_q     <= 5'b11110;
        end
      endcase
    end
  end

  assign col_no      = col_q;
  assign buttons_o   = buttons_q;
  assign scan_done_o = scan_done_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Drives a behavioural key matrix (keys[k] = 1 means key k is held) against
// keypad_scanner with SETTLE_CYCLES=3, DEBOUNCE_SCANS=3. The expected
// buttons_o comes from a history of whole-matrix snapshots: the output takes
// a snapshot's value once the last DEBOUNCE_SCANS snapshots are identical.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_keypad_scanner;
  import calc_pkg::*;

  localparam int SETTLE = 3;
  localparam int DEB    = 3;
  localparam int PERIOD = 5 * (SETTLE + 1) + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  row_n;
  logic [4:0]  col_n;
  buttons_t    btn;
  logic        done;

  logic [24:0] keys;
  logic [22:0] exp_btn;
  logic [22:0] hist[$];

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SETTLE_CYCLES (SETTLE),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .row_ni     (row_n),
    .col_no     (col_n),
    .buttons_o  (btn),
    .scan_done_o(done)
  );

  // Passive matrix: a held key shorts its row to the driven (low) column.
  always_comb begin
    row_n = 5'b11111;
    for (int c = 0; c < 5; c++) begin
      if (!col_n[c]) begin
        for (int r = 0; r < 5; r++) begin
          if (keys[c*5+r]) row_n[r] = 1'b0;
        end
      end
    end
  end

  function automatic logic [22:0] to_vec(buttons_t b);
    logic [22:0] v;
    v[0]  = b.on;         v[1]  = b.off;      v[2]  = b.mem_rc;
    v[3]  = b.mem_sub;    v[4]  = b.mem_add;  v[5]  = b.op_percent;
    v[6]  = b.op_sqrt;    v[7]  = b.op_div;   v[8]  = b.op_mul;
    v[9]  = b.op_sub;     v[10] = b.op_add;   v[11] = b.op_eq;
    v[12] = b.dot;        v[13] = b.num_1;    v[14] = b.num_2;
    v[15] = b.num_3;      v[16] = b.num_4;    v[17] = b.num_5;
    v[18] = b.num_6;      v[19] = b.num_7;    v[20] = b.num_8;
    v[21] = b.num_9;      v[22] = b.num_0;
    return v;
  endfunction

  // ---------------- reference model ----------------
  task automatic model_reset();
    hist.delete();
    exp_btn = '0;
  endtask

  task automatic model_scan(input logic [22:0] s);
    bit same;
    hist.push_back(s);
    if (hist.size() > DEB) void'(hist.pop_front());
    if (hist.size() == DEB) begin
      same = 1'b1;
      foreach (hist[i]) if (hist[i] !== s) same = 1'b0;
      if (same) exp_btn = s;
    end
  endtask

  // Reset for two cycles; returns at the negedge where rst_n deasserts.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Wait for n scans, checking that buttons_o holds until the edge after
  // S_EVAL and takes the model's value right after it. Keys are assumed
  // steady within each scan; callers change them only between scans.
  task automatic run_scans(input int n);
    bit found;
    for (int i = 0; i < n; i++) begin
      found = 1'b0;
      for (int c = 0; c < 2 * PERIOD && !found; c++) begin
        @(negedge clk);
        if (done === 1'b1) begin
          found = 1'b1;
        end else begin
          total++;
          if (to_vec(btn) !== exp_btn)
            $display("FAIL hold: buttons=%h required %h", to_vec(btn), exp_btn);
          else passed++;
        end
      end
      total++;
      if (!found) $display("FAIL scan_timeout: scan_done=%b required 1 within %0d cycles", done, 2 * PERIOD);
      else passed++;
      if (found) begin
        total++;
        if (to_vec(btn) !== exp_btn)
          $display("FAIL pre_update: buttons=%h required %h", to_vec(btn), exp_btn);
        else passed++;
        model_scan(keys[22:0]);
        @(posedge clk);
        #1;
        total++;
        if (to_vec(btn) !== exp_btn)
          $display("FAIL post_update: buttons=%h required %h", to_vec(btn), exp_btn);
        else passed++;
        total++;
        if (done !== 1'b0)
          $display("FAIL done_width: scan_done=%b required 0", done);
        else passed++;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    keys  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    total++;
    if (col_n !== 5'b11110) $display("FAIL reset_col: col=%b required 11110", col_n);
    else passed++;
    total++;
    if (to_vec(btn) !== 23'h0) $display("FAIL reset_buttons: buttons=%h required 0", to_vec(btn));
    else passed++;
    total++;
    if (done !== 1'b0) $display("FAIL reset_done: scan_done=%b required 0", done);
    else passed++;
  endtask

  task automatic test_idle();
    int pm, idx;
    logic [4:0] exp_col;
    logic       exp_done;
    keys = '0;
    do_reset();
    #1;
    for (int p = 0; p <= 2 * PERIOD + 2; p++) begin
      if (p != 0) begin
        @(posedge clk);
        #1;
      end
      pm       = p % PERIOD;
      idx      = (pm < 20) ? pm / 4 : 4;
      exp_col  = ~(5'b00001 << idx);
      exp_done = (pm == PERIOD - 1);
      total++;
      if (col_n !== exp_col) $display("FAIL idle_col: phase %0d col=%b required %b", pm, col_n, exp_col);
      else passed++;
      total++;
      if (done !== exp_done) $display("FAIL idle_done: phase %0d scan_done=%b required %b", pm, done, exp_done);
      else passed++;
    end
    total++;
    if (to_vec(btn) !== 23'h0) $display("FAIL idle_buttons: buttons=%h required 0", to_vec(btn));
    else passed++;
  endtask

  task automatic test_single_key();
    keys     = '0;
    keys[11] = 1'b1;
    do_reset();
    run_scans(2);
    total++;
    if (to_vec(btn) !== 23'h0) $display("FAIL key_early: buttons=%h required 0", to_vec(btn));
    else passed++;
    run_scans(1);
    total++;
    if (btn.op_eq !== 1'b1 || to_vec(btn) !== 23'h000800)
      $display("FAIL key_press: buttons=%h required 000800", to_vec(btn));
    else passed++;
    // Release: clears after three further identical scans.
    keys = '0;
    run_scans(2);
    total++;
    if (btn.op_eq !== 1'b1) $display("FAIL release_early: op_eq=%b required 1", btn.op_eq);
    else passed++;
    run_scans(1);
    total++;
    if (to_vec(btn) !== 23'h0) $display("FAIL release: buttons=%h required 0", to_vec(btn));
    else passed++;
  endtask

  task automatic test_bounce();
    keys = '0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_scans(1);
      keys[11] = ~keys[11];
    end
    total++;
    if (to_vec(btn) !== 23'h0) $display("FAIL bounce: buttons=%h required 0", to_vec(btn));
    else passed++;
    keys = '0;
    run_scans(3);
  endtask

  task automatic test_unpopulated();
    keys     = '0;
    keys[0]  = 1'b1;
    keys[23] = 1'b1;
    keys[24] = 1'b1;
    do_reset();
    run_scans(3);
    total++;
    if (btn.on !== 1'b1 || to_vec(btn) !== 23'h000001)
      $display("FAIL unpopulated: buttons=%h required 000001", to_vec(btn));
    else passed++;
    keys = '0;
    run_scans(3);
  endtask

  task automatic test_reset_mid();
    bit found;
    keys     = '0;
    keys[11] = 1'b1;
    do_reset();
    run_scans(4);
    found = 1'b0;
    for (int c = 0; c < 2 * PERIOD && !found; c++) begin
      @(negedge clk);
      if (col_n === 5'b10111) found = 1'b1;
    end
    total++;
    if (!found) $display("FAIL col3_timeout: col=%b required 10111", col_n);
    else passed++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (to_vec(btn) !== 23'h0) $display("FAIL midreset_buttons: buttons=%h required 0", to_vec(btn));
    else passed++;
    total++;
    if (col_n !== 5'b11110) $display("FAIL midreset_col: col=%b required 11110", col_n);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_scans(3);
    total++;
    if (to_vec(btn) !== 23'h000800) $display("FAIL midreset_rereport: buttons=%h required 000800", to_vec(btn));
    else passed++;
    keys = '0;
    run_scans(3);
  endtask

  task automatic test_random();
    keys = '0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      run_scans(1);
      if ($urandom_range(0, 2) == 0) begin
        keys = '0;
        for (int j = 0; j < int'($urandom_range(0, 3)); j++)
          keys[$urandom_range(0, 24)] = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_key();
    test_bounce();
    test_unpopulated();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
